// File: rtl/tbt_op_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tbt_op_master : streams two 2x2 operand matrices to an external adder and
//                 streams the 2x2 sum back out. Watchdog: TBT_OP_MASTER_WATCHDOG_EN
// Revision 1.0
// ----------------------------------------------------------------------------
module tbt_op_master #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         A_stb,
   output logic         B_stb,
   output logic [127:0] A,
   output logic [127:0] B,
   input  logic         result_ready,
   input  logic [127:0] result,
   output logic         result_ack,
   output logic [31:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
`ifdef TBT_OP_MASTER_WATCHDOG_EN
   ,
   output logic         timeout_err
`endif
);

   typedef enum logic [2:0] {
      S_LOAD     = 3'd0,
      S_REQ      = 3'd1,
      S_WAIT_RES = 3'd2,
      S_ACK      = 3'd3,
      S_DRAIN    = 3'd4
   } state_t;

   state_t         state_q;
   logic [2:0]     cnt_q;
   logic [1:0]     idx_q;
   logic [127:0]   a_q;
   logic [127:0]   b_q;
   logic [127:0]   buf_q;

`ifdef TBT_OP_MASTER_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_q;
   logic            timeout_err_q;
   assign timeout_err = timeout_err_q;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES < 1);
`endif

   // Handshake outputs decode the registered state; reset masks them in the reset cycle too.
   assign in_ready   = !reset && (state_q == S_LOAD);
   assign A_stb      = !reset && (state_q == S_REQ) && !result_ready;
   assign B_stb      = A_stb;
   assign result_ack = !reset && (state_q == S_ACK);
   assign out_valid  = !reset && (state_q == S_DRAIN);
   assign busy       = !reset && (state_q != S_LOAD);
   assign A          = a_q;
   assign B          = b_q;
   assign out_data   = buf_q[{idx_q, 5'b0} +: 32];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_LOAD;
         cnt_q   <= 3'd0;
         idx_q   <= 2'd0;
         a_q     <= '0;
         b_q     <= '0;
         buf_q   <= '0;
`ifdef TBT_OP_MASTER_WATCHDOG_EN
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  if (!cnt_q[2]) a_q[{cnt_q[1:0], 5'b0} +: 32] <= in_data;
                  else           b_q[{cnt_q[1:0], 5'b0} +: 32] <= in_data;
                  cnt_q <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) state_q <= S_REQ;
               end
            end
            // A stale result_ready from the previous operation must fall before we strobe.
            S_REQ: begin
               if (!result_ready) begin
                  state_q <= S_WAIT_RES;
`ifdef TBT_OP_MASTER_WATCHDOG_EN
                  wd_cnt_q <= '0;
`endif
               end
            end
            S_WAIT_RES: begin
               if (result_ready) begin
                  buf_q   <= result;
                  state_q <= S_ACK;
               end
`ifdef TBT_OP_MASTER_WATCHDOG_EN
               else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= S_LOAD;
               end else begin
                  wd_cnt_q <= wd_cnt_q + WD_W'(1);
               end
`endif
            end
            S_ACK: begin
               idx_q   <= 2'd0;
               state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (out_ready) begin
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) state_q <= S_LOAD;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tbt_op_master.sv
`default_nettype none
// Randomized bench for tbt_op_master: stimulus pushes expectations into queues,
// an adder model and an output monitor pop and compare them.
module tb_tbt_op_master;

   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic         A_stb, B_stb;
   logic [127:0] A, B;
   logic         result_ready;
   logic [127:0] result;
   logic         result_ack;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
`ifdef TBT_OP_MASTER_WATCHDOG_EN
   logic         timeout_err;
`endif

   tbt_op_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .A_stb(A_stb), .B_stb(B_stb), .A(A), .B(B),
      .result_ready(result_ready), .result(result), .result_ack(result_ack),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
`ifdef TBT_OP_MASTER_WATCHDOG_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [127:0] exp_a_q[$];
   logic [127:0] exp_b_q[$];
   logic [127:0] res_q[$];
   logic [31:0]  out_q[$];
   logic [31:0]  wbuf[8];

   int           w7_cyc = 0;
   int           rr_drop_cyc = 0;
   int           ack_cyc = -100;
   int           mode = 2;
   int           force_linger = 0;
   bit           mute = 1'b0;
   logic [127:0] strobe_a = '0;
   logic [127:0] strobe_b = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   task automatic reset_chk();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_stb", {A_stb, B_stb}, 0);
      chk("rst_ack", result_ack, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_out_data", out_data, 0);
`ifdef TBT_OP_MASTER_WATCHDOG_EN
      chk("rst_timeout_err", timeout_err, 0);
`endif
   endtask

   // Offer n words from wbuf; each stays pending until the DUT takes it.
   task automatic send(input int n);
      for (int k = 0; k < n; k++) begin
         int guard;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = wbuf[k];
         guard    = 0;
         @(negedge clk);
         while (!in_ready && guard < 400) begin
            guard++;
            @(negedge clk);
         end
         if (!in_ready) begin
            chk("in_ready_wait", 0, 1);
            finish_run();
         end
         if (k == 7) w7_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // One full operation. Directed: A=B={1.0,2.0,3.0,4.0}, adder returns 2A
   // (doubling a normal single-precision value adds one to its exponent).
   task automatic op(input bit directed, input bit respond);
      logic [127:0] a, b, r;
      if (directed) begin
         wbuf[0] = 32'h3F800000; wbuf[1] = 32'h40000000;
         wbuf[2] = 32'h40400000; wbuf[3] = 32'h40800000;
         for (int k = 4; k < 8; k++) wbuf[k] = wbuf[k-4];
      end else begin
         for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      end
      a = {wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
      b = {wbuf[7], wbuf[6], wbuf[5], wbuf[4]};
      if (directed) begin
         for (int m = 0; m < 4; m++) r[m*32 +: 32] = wbuf[m] + 32'h00800000;
      end else begin
         r = {$urandom, $urandom, $urandom, $urandom};
      end
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      if (respond) begin
         res_q.push_back(r);
         for (int m = 0; m < 4; m++) out_q.push_back(r[m*32 +: 32]);
      end
      send(8);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      @(negedge clk);
      while ((out_q.size() != 0 || exp_a_q.size() != 0 || busy) && g < 3000) begin
         g++;
         @(negedge clk);
      end
      chk("drained_outputs", out_q.size(), 0);
      chk("drained_strobes", exp_a_q.size(), 0);
      if (g >= 3000) finish_run();
      @(posedge clk); #1;
   endtask

   // Adder model: checks operands at each strobe and answers after a random delay.
   int adder_d, adder_l, adder_g, adder_rise, adder_exp;
   initial begin
      result_ready = 1'b0;
      result       = '0;
      forever begin
         @(negedge clk);
         if (A_stb) begin
            strobe_a = A;
            strobe_b = B;
            chk("stb_pair", B_stb, 1);
            adder_exp = (w7_cyc + 1 > rr_drop_cyc) ? w7_cyc + 1 : rr_drop_cyc;
            chk("stb_latency", cyc, adder_exp);
            if (exp_a_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               chk("operand_A", A, exp_a_q.pop_front());
               chk("operand_B", B, exp_b_q.pop_front());
            end
            if (!mute) begin
               adder_d = $urandom_range(0, 3);
               @(posedge clk); #1;
               repeat (adder_d) begin @(posedge clk); #1; end
               if (res_q.size() == 0) begin
                  chk("adder_result_missing", 1, 0);
                  result = '0;
               end else begin
                  result = res_q.pop_front();
               end
               result_ready = 1'b1;
               adder_rise   = cyc;
               adder_g      = 0;
               @(negedge clk);
               while (!result_ack && adder_g < 50) begin
                  adder_g++;
                  @(negedge clk);
               end
               chk("ack_latency", cyc, adder_rise + 1);
               ack_cyc = cyc;
               if (force_linger > 0) adder_l = force_linger;
               else adder_l = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
               for (int i = 0; i < adder_l; i++) begin
                  @(posedge clk); #1;
                  result = {$urandom, $urandom, $urandom, $urandom};
               end
               @(posedge clk); #1;
               result_ready = 1'b0;
               rr_drop_cyc  = cyc;
            end
         end
      end
   end

   logic ack_prev = 1'b0;
   always @(negedge clk) begin
      if (ack_prev) chk("ack_single_cycle", result_ack, 0);
      ack_prev = result_ack;
      if (result_ready && !reset) chk("no_stb_while_rr", A_stb, 0);
   end

   // Output monitor: every valid cycle must show the head of the expected queue.
   bit out_prev_valid = 1'b0;
   int out_widx = 0;
   always @(negedge clk) begin
      if (out_valid) begin
         if (!out_prev_valid) chk("first_out_latency", cyc, ack_cyc + 1);
         if (out_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            chk("out_word", out_data, out_q[0]);
            if (out_ready) void'(out_q.pop_front());
         end
         if (out_ready) begin
            if (mode == 2) chk("drain_back_to_back", cyc, ack_cyc + 1 + out_widx);
            out_widx = (out_widx == 3) ? 0 : out_widx + 1;
         end
      end
      out_prev_valid = out_valid;
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      #500000;
      chk("global_time_limit", 1, 0);
      finish_run();
   end

   initial begin
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_chk();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_release", in_ready, 1);
      chk("idle_not_busy", busy, 0);
      @(posedge clk); #1;

      mode = 2;
      op(1'b1, 1'b1);
      wait_idle();
      chk("directed_A_packed", strobe_a, 128'h40800000_40400000_40000000_3F800000);
      chk("directed_B_packed", strobe_b, 128'h40800000_40400000_40000000_3F800000);

      mode = 1;
      op(1'b1, 1'b1);
      wait_idle();

      mode = 2;
      force_linger = 20;
      op(1'b0, 1'b1);
      op(1'b0, 1'b1);
      force_linger = 0;
      wait_idle();

      mode = 0;
      repeat (20) op(1'b0, 1'b1);
      wait_idle();

      mode = 2;
      repeat (5) op(1'b0, 1'b1);
      wait_idle();

      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      send(5);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_chk();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_midop_reset", in_ready, 1);
      @(posedge clk); #1;
      op(1'b0, 1'b1);
      wait_idle();

`ifdef TBT_OP_MASTER_WATCHDOG_EN
      begin
         int s;
         repeat (20) @(posedge clk);
         #1;
         mute = 1'b1;
         op(1'b0, 1'b0);
         s = w7_cyc + 1;
         while (cyc < s + 16) begin
            @(negedge clk);
            chk("wd_no_ack", result_ack, 0);
            chk("wd_err_low", timeout_err, 0);
         end
         @(negedge clk);
         chk("wd_err_set", timeout_err, 1);
         chk("wd_in_ready", in_ready, 1);
         chk("wd_no_ack_after", result_ack, 0);
         @(posedge clk); #1;
         mute = 1'b0;
         op(1'b0, 1'b1);
         wait_idle();
         chk("wd_err_sticky", timeout_err, 1);
         reset = 1'b1;
         @(posedge clk);
         @(negedge clk);
         reset_chk();
         @(posedge clk); #1;
         reset = 1'b0;
      end
`endif

      repeat (5) @(posedge clk);
      chk("final_res_queue", res_q.size(), 0);
      chk("final_out_queue", out_q.size(), 0);
      finish_run();
   end

endmodule
`default_nettype wire
